// File: rtl/instr_pkg.sv
`default_nettype none
// ============================================================================
// Module   : instr_pkg
// Brief    : Operation codes and RV32I field constants for the encoder.
// Revision : 1.0 - initial release
// ============================================================================
package instr_pkg;

  typedef enum logic [2:0] {
    c_op_add = 3'd0,
    c_op_sub = 3'd1,
    c_op_lw  = 3'd2,
    c_op_sw  = 3'd3,
    c_op_beq = 3'd4
  } op_e;

  localparam logic [6:0] c_opc_op     = 7'b0110011;
  localparam logic [6:0] c_opc_load   = 7'b0000011;
  localparam logic [6:0] c_opc_store  = 7'b0100011;
  localparam logic [6:0] c_opc_branch = 7'b1100011;

  localparam logic [2:0] c_f3_add_sub = 3'b000;
  localparam logic [2:0] c_f3_word    = 3'b010;
  localparam logic [2:0] c_f3_beq     = 3'b000;

  localparam logic [6:0] c_f7_add = 7'b0000000;
  localparam logic [6:0] c_f7_sub = 7'b0100000;

  function automatic logic is_legal_op(input logic [2:0] op);
    return (op <= 3'd4);
  endfunction

endpackage
`default_nettype wire

// File: rtl/instr_fifo.sv
`default_nettype none
// ============================================================================
// Module   : instr_fifo
// Brief    : Synchronous 32-bit FIFO, DEPTH entries (power of two).
// Revision : 1.0 - initial release
// ============================================================================
module instr_fifo #(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic [31:0]              din,
  output logic [31:0]              dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] c_full_count = (PTR_W+1)'(DEPTH);

  logic [31:0]      r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W:0]   r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign full      = (r_count == c_full_count);
  assign empty     = (r_count == '0);
  assign count     = r_count;
  assign dout      = r_mem[r_rd_ptr];
  assign w_do_push = push & ~full;
  assign w_do_pop  = pop & ~empty;

  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr] <= din;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      end
      if (w_do_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + (PTR_W+1)'(1);
        2'b01:   r_count <= r_count - (PTR_W+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/instr_encoder.sv
`default_nettype none
// ============================================================================
// Module   : instr_encoder
// Brief    : Encodes ADD/SUB/LW/SW/BEQ requests into RV32I words, buffered.
// Revision : 1.0 - initial release
// ============================================================================
module instr_encoder
  import instr_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [2:0]             in_op,
  input  logic [4:0]             in_rd,
  input  logic [4:0]             in_rs1,
  input  logic [4:0]             in_rs2,
  input  logic [11:0]            in_imm,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [31:0]            out_instr,
  output logic [ADDR_W-1:0]      out_addr,
  output logic                   err,
  output logic [$clog2(DEPTH):0] count
);

  logic [31:0]       w_instr;
  logic              w_legal;
  logic              w_accept;
  logic              w_push;
  logic              w_pop;
  logic              w_full;
  logic              w_empty;
  logic [31:0]       w_head;
  logic              r_err;
  logic [ADDR_W-1:0] r_addr;

  always_comb begin
    w_instr = '0;
    w_legal = is_legal_op(in_op);
    case (in_op)
      c_op_add: w_instr = {c_f7_add, in_rs2, in_rs1, c_f3_add_sub, in_rd, c_opc_op};
      c_op_sub: w_instr = {c_f7_sub, in_rs2, in_rs1, c_f3_add_sub, in_rd, c_opc_op};
      c_op_lw:  w_instr = {in_imm, in_rs1, c_f3_word, in_rd, c_opc_load};
      c_op_sw:  w_instr = {in_imm[11:5], in_rs2, in_rs1, c_f3_word, in_imm[4:0], c_opc_store};
      // in_imm holds imm[12:1] of the branch offset, so every index is shifted down by one
      c_op_beq: w_instr = {in_imm[11], in_imm[9:4], in_rs2, in_rs1, c_f3_beq,
                           in_imm[3:0], in_imm[10], c_opc_branch};
      default:  w_instr = '0;
    endcase
  end

  assign in_ready  = ~w_full;
  assign w_accept  = in_valid & in_ready;
  assign w_push    = w_accept & w_legal;
  assign out_valid = ~w_empty;
  assign w_pop     = out_valid & out_ready;
  assign out_instr = w_empty ? 32'd0 : w_head;
  assign out_addr  = r_addr;
  assign err       = r_err;

  instr_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (w_push),
    .pop   (w_pop),
    .din   (w_instr),
    .dout  (w_head),
    .full  (w_full),
    .empty (w_empty),
    .count (count)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_err  <= 1'b0;
      r_addr <= '0;
    end else begin
      r_err <= w_accept & ~w_legal;
      if (w_pop) begin
        r_addr <= r_addr + ADDR_W'(1);
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_instr_encoder.sv
`default_nettype none
// ============================================================================
// Module   : tb_instr_encoder
// Brief    : Scoreboard bench for instr_encoder with directed vectors.
// Revision : 1.0 - initial release
// ============================================================================
module tb_instr_encoder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [2:0]  in_op = '0;
  logic [4:0]  in_rd = '0;
  logic [4:0]  in_rs1 = '0;
  logic [4:0]  in_rs2 = '0;
  logic [11:0] in_imm = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_instr;
  logic [7:0]  out_addr;
  logic        err;
  logic [2:0]  count;

  int          errors = 0;
  int          checks = 0;
  logic [31:0] exp_q[$];
  logic [7:0]  mon_addr = '0;

  instr_encoder #(.DEPTH(4), .ADDR_W(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_op     (in_op),
    .in_rd     (in_rd),
    .in_rs1    (in_rs1),
    .in_rs2    (in_rs2),
    .in_imm    (in_imm),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_instr (out_instr),
    .out_addr  (out_addr),
    .err       (err),
    .count     (count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  function automatic logic [11:0] bimm(input logic [31:0] w);
    return {w[31], w[7], w[30:25], w[11:8]};
  endfunction

  // Monitor: pops the scoreboard whenever the DUT will pop on the next edge
  initial begin
    logic [31:0] e;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        exp_q.delete();
        mon_addr = '0;
      end else if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_pop: got 0x%0h, expected no word", out_instr);
        end else begin
          e = exp_q.pop_front();
          chk("sb_instr", out_instr, e);
          chk("sb_addr", 32'(out_addr), 32'(mon_addr));
          mon_addr = mon_addr + 8'd1;
        end
      end
    end
  end

  task automatic send(input logic [2:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                      input logic [4:0] rs2, input logic [11:0] imm, input logic [31:0] exp);
    int n = 0;
    in_valid = 1'b1; in_op = op; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2; in_imm = imm;
    while (!in_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: got in_ready=0, expected 1 within 50 cycles");
      in_valid = 1'b0;
      return;
    end
    if (op <= 3'd4) exp_q.push_back(exp);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic one_word(input string name, input logic [2:0] op, input logic [4:0] rd,
                          input logic [4:0] rs1, input logic [4:0] rs2, input logic [11:0] imm,
                          input logic [31:0] exp, input logic [7:0] addr, output logic [31:0] got);
    out_ready = 1'b0;
    send(op, rd, rs1, rs2, imm, exp);
    chk({name, "_valid"}, 32'(out_valid), 32'd1);
    chk({name, "_head"}, out_instr, exp);
    chk({name, "_addr"}, 32'(out_addr), 32'(addr));
    got = out_instr;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic wait_empty();
    int n = 0;
    while (exp_q.size() != 0 && n < 600) begin
      @(posedge clk); #1;
      n++;
    end
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: got %0d words pending, expected 0", exp_q.size());
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, expected end of test");
    $fatal(1);
  end

  initial begin
    logic [31:0] w;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_instr", out_instr, 32'd0);
    chk("rst_addr", 32'(out_addr), 32'd0);
    chk("rst_ready", 32'(in_ready), 32'd1);
    chk("rst_err", 32'(err), 32'd0);
    rst_n = 1'b1;

    one_word("lw",  3'd2, 5'd5, 5'd2, 5'd0, 12'h555, 32'h55512283, 8'd0, w);
    one_word("sw",  3'd3, 5'd0, 5'd1, 5'd3, 12'h555, 32'h5430AAA3, 8'd1, w);
    one_word("beq", 3'd4, 5'd0, 5'd0, 5'd0, 12'h07F, 32'h0E000F63, 8'd2, w);
    chk("beq_immgen", 32'(bimm(w)), 32'h07F);
    one_word("add", 3'd0, 5'd1, 5'd2, 5'd3, 12'h000, 32'h003100B3, 8'd3, w);
    one_word("sub", 3'd1, 5'd1, 5'd2, 5'd3, 12'hFFF, 32'h403100B3, 8'd4, w);
    chk("empty_valid", 32'(out_valid), 32'd0);
    chk("empty_instr", out_instr, 32'd0);

    // Back-pressure: four fill the FIFO, the fifth waits
    do_reset();
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++)
      send(3'd0, 5'(i + 1), 5'd2, 5'd3, 12'h000, 32'h00310033 | ((i + 1) << 7));
    in_valid = 1'b1; in_op = 3'd0; in_rd = 5'd5; in_rs1 = 5'd2; in_rs2 = 5'd3;
    chk("full_ready", 32'(in_ready), 32'd0);
    chk("full_count", 32'(count), 32'd4);
    repeat (2) @(posedge clk);
    #1;
    chk("hold_count", 32'(count), 32'd4);
    chk("hold_instr", out_instr, 32'h003100B3);
    chk("hold_addr", 32'(out_addr), 32'd0);
    out_ready = 1'b1;
    send(3'd0, 5'd5, 5'd2, 5'd3, 12'h000, 32'h003102B3);
    wait_empty();
    chk("drain_count", 32'(count), 32'd0);

    // Illegal op with two words parked
    out_ready = 1'b0;
    send(3'd0, 5'd6, 5'd0, 5'd0, 12'h000, 32'h00000333);
    send(3'd0, 5'd7, 5'd0, 5'd0, 12'h000, 32'h000003B3);
    chk("pre_ill_count", 32'(count), 32'd2);
    send(3'd7, 5'd1, 5'd1, 5'd1, 12'h001, 32'd0);
    chk("ill_err", 32'(err), 32'd1);
    chk("ill_count", 32'(count), 32'd2);
    chk("ill_valid", 32'(out_valid), 32'd1);
    @(posedge clk); #1;
    chk("ill_err_clear", 32'(err), 32'd0);

    // Illegal op coinciding with a pop
    out_ready = 1'b1;
    send(3'd5, 5'd1, 5'd1, 5'd1, 12'h001, 32'd0);
    chk("ill_pop_err", 32'(err), 32'd1);
    chk("ill_pop_count", 32'(count), 32'd1);
    wait_empty();

    // 257 words streamed through: address wraps 255 -> 0 -> 1
    do_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 257; i++)
      send(3'd0, 5'(i), 5'd0, 5'd0, 12'h000, 32'h00000033 | ((i % 32) << 7));
    wait_empty();
    @(posedge clk); #1;
    chk("wrap_addr", 32'(out_addr), 32'd1);

    // Reset with three words in flight and a request held during reset
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++)
      send(3'd0, 5'(i), 5'd0, 5'd0, 12'h000, 32'h00000033 | (i << 7));
    chk("pre_rst_count", 32'(count), 32'd3);
    in_valid = 1'b1; in_op = 3'd0;
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk("midrst_count", 32'(count), 32'd0);
    chk("midrst_valid", 32'(out_valid), 32'd0);
    chk("midrst_addr", 32'(out_addr), 32'd0);
    chk("midrst_instr", out_instr, 32'd0);
    chk("midrst_ready", 32'(in_ready), 32'd1);
    in_valid = 1'b0;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_count", 32'(count), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/instr_encoder.md
INSTR_ENCODER -- requirements
Module: instr_encoder

Interface
REQ-001 The module SHALL have parameter DEPTH, default 4, giving the number of output FIFO entries (power of two).
REQ-002 The module SHALL have parameter ADDR_W, default 8, giving the width of the instruction word address.
REQ-003 The module SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-004 The module SHALL have port rst_n  input  1  reset, synchronous and active-low.
REQ-005 The module SHALL have port in_valid  input  1  request present.
REQ-006 The module SHALL have port in_ready  output  1  request can be accepted.
REQ-007 The module SHALL have port in_op  input  3  operation: 0 ADD, 1 SUB, 2 LW, 3 SW, 4 BEQ, 5-7 illegal.
REQ-008 The module SHALL have ports in_rd, in_rs1 and in_rs2  input  5 each  register fields.
REQ-009 The module SHALL have port in_imm  input  12  immediate; for BEQ it carries imm[12:1].
REQ-010 The module SHALL have port out_valid  output  1  head word valid.
REQ-011 The module SHALL have port out_ready  input  1  consumer accepts head word.
REQ-012 The module SHALL have port out_instr  output  32  encoded RV32I word.
REQ-013 The module SHALL have port out_addr  output  ADDR_W  word address of the head word.
REQ-014 The module SHALL have port err  output  1  one-cycle illegal-op pulse.
REQ-015 The module SHALL have port count  output  $clog2(DEPTH)+1  FIFO occupancy.

Function
REQ-016 The module SHALL accept a request on an edge where in_valid and in_ready are both 1, and SHALL drive in_ready = (count < DEPTH), with no full-bypass.
REQ-017 The module SHALL encode ADD/SUB as R-type: {funct7, rs2, rs1, 000, rd, 0110011}, with funct7 0000000 for ADD and 0100000 for SUB, and in_imm ignored.
REQ-018 The module SHALL encode LW as {imm[11:0], rs1, 010, rd, 0000011}, with in_rs2 ignored.
REQ-019 The module SHALL encode SW as {imm[11:5], rs2, rs1, 010, imm[4:0], 0100011}, with in_rd ignored.
REQ-020 The module SHALL encode BEQ as {imm[11], imm[9:4], rs2, rs1, 000, imm[3:0], imm[10], 1100011}, with in_rd ignored, so that the immediate generator recovers in_imm exactly.
REQ-021 The module SHALL write a legal accepted word into the FIFO tail on the accept edge, making it visible at the head one cycle later when the FIFO was empty (latency 1).
REQ-022 The module SHALL consume an illegal op without enqueueing it, assert err for exactly the next cycle, and leave count unchanged.
REQ-023 The module SHALL drive out_valid = (count != 0), and SHALL drive out_instr = 0 when the FIFO is empty.
REQ-024 The module SHALL perform a pop on an edge where out_valid and out_ready are both 1.
REQ-025 On each pop, the module SHALL increment the address counter by 1, wrapping from 2^ADDR_W-1 to 0, and out_addr SHALL equal the counter value.
REQ-026 On a simultaneous push and pop while not full, the module SHALL leave count unchanged and preserve FIFO order.
REQ-027 On a simultaneous illegal accept and pop, the module SHALL perform the pop and also pulse err.
REQ-028 When out_ready is 0, the module SHALL hold out_instr and out_addr stable while out_valid is 1.

Reset
REQ-029 When rst_n=0 at a clock edge, the module SHALL set count=0, the address counter=0, err=0, and FIFO pointers=0, giving out_valid=0, out_instr=0, out_addr=0 and in_ready=1.
REQ-030 The module SHALL discard in-flight entries when reset is asserted mid-operation, and SHALL NOT accept any request during a reset cycle.

Structure
REQ-031 The design SHALL place the in_op encodings, the opcode constants (0110011, 0000011, 0100011, 1100011), and the funct3/funct7 constants in a shared package, instr_pkg.
REQ-032 The design SHALL implement the encoder as combinational logic inside instr_encoder.
REQ-033 The design SHALL implement storage as one sub-module, instr_fifo, a synchronous FIFO with DEPTH entries of 32-bit width and push, pop, full, empty and count signals.

Verification
REQ-034 The bench SHALL cover: LW rd=5 rs1=2 imm=0x555 -> out_instr=0x55512283, out_addr=0, one cycle after accept.
REQ-035 The bench SHALL cover: SW rs1=1 rs2=3 imm=0x555 -> 0x5430AAA3; BEQ rs1=0 rs2=0 imm=0x07F -> 0x0E000F63, and the immediate generator fed this word returns 0x07F.
REQ-036 The bench SHALL cover: ADD rd=1 rs1=2 rs2=3 -> 0x003100B3; SUB with the same fields -> 0x403100B3.
REQ-037 The bench SHALL cover: out_ready=0 with 5 back-to-back legal requests -> in_ready=0 after 4 accepts and count=4; then out_ready=1 -> 4 words popped in order at out_addr 0,1,2,3.
REQ-038 The bench SHALL cover: in_op=7 -> err=1 for one cycle, count unchanged, out_valid unchanged.
REQ-039 The bench SHALL cover: 256 pops -> out_addr wraps 255->0; and rst_n=0 with count=3 -> next cycle count=0, out_valid=0, out_addr=0.
